// File: rtl/guess_entry.sv
// Guess entry: assembles three BCD digits from keypad events and submits them
// on enter, followed by a key lockout. Optional macro GUESS_DISTINCT_EN refuses repeated digits.
module guess_entry #(
    parameter int HOLD_CYCLES = 4,
    parameter int GCNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [3:0]        num1,
    output logic [3:0]        num2,
    output logic [3:0]        num3,
    output logic              num_rdy,
    output logic [1:0]        ent_cnt,
    output logic              busy,
    output logic              key_reject,
    output logic [GCNT_W-1:0] sub_cnt
);

    typedef enum logic {ENTRY, HOLD} state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);

    state_t                  state_q, state_d;
    logic [7:0]              hold_q, hold_d;
    logic [2:0][3:0]         e_q, e_d;
    logic [1:0]              ent_q, ent_d;
    logic [3:0]              n1_q, n1_d, n2_q, n2_d, n3_q, n3_d;
    logic                    rdy_q, rdy_d;
    logic                    busy_q, busy_d;
    logic                    rej_q, rej_d;
    logic [GCNT_W-1:0]       sub_cnt_q, sub_cnt_d;
    logic                    dup;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        e_d       = e_q;
        ent_d     = ent_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        n3_d      = n3_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;
        rej_d     = 1'b0;
        sub_cnt_d = sub_cnt_q;
        dup       = 1'b0;
`ifdef GUESS_DISTINCT_EN
        for (int i = 0; i < 3; i++) begin
            if (i < int'(ent_q) && e_q[i] == key_code) dup = 1'b1;
        end
`endif
        case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (ent_q == 2'd3 || dup) begin
                            rej_d = 1'b1;
                        end else begin
                            e_d[ent_q] = key_code;
                            ent_d      = ent_q + 2'd1;
                        end
                    end else begin
                        case (key_code)
                            4'hB: begin
                                if (ent_q != 2'd0) begin
                                    e_d[ent_q - 2'd1] = 4'd0;
                                    ent_d             = ent_q - 2'd1;
                                end
                            end
                            4'hE: begin
                                e_d   = '0;
                                ent_d = 2'd0;
                            end
                            4'hF: begin
                                if (ent_q == 2'd3) begin
                                    n1_d   = e_q[0];
                                    n2_d   = e_q[1];
                                    n3_d   = e_q[2];
                                    rdy_d  = 1'b1;
                                    if (sub_cnt_q != '1) sub_cnt_d = sub_cnt_q + GCNT_W'(1);
                                    e_d     = '0;
                                    ent_d   = 2'd0;
                                    busy_d  = 1'b1;
                                    hold_d  = HOLD_LD;
                                    state_d = HOLD;
                                end else begin
                                    rej_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            HOLD: begin
                // Keys are dropped silently; busy falls with the return to ENTRY.
                if (hold_q == 8'd1) begin
                    state_d = ENTRY;
                    busy_d  = 1'b0;
                    hold_d  = 8'd0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ENTRY;
            hold_q    <= '0;
            e_q       <= '0;
            ent_q     <= '0;
            n1_q      <= '0;
            n2_q      <= '0;
            n3_q      <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            rej_q     <= 1'b0;
            sub_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            e_q       <= e_d;
            ent_q     <= ent_d;
            n1_q      <= n1_d;
            n2_q      <= n2_d;
            n3_q      <= n3_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            rej_q     <= rej_d;
            sub_cnt_q <= sub_cnt_d;
        end
    end

    assign num1       = n1_q;
    assign num2       = n2_q;
    assign num3       = n3_q;
    assign num_rdy    = rdy_q;
    assign ent_cnt    = ent_q;
    assign busy       = busy_q;
    assign key_reject = rej_q;
    assign sub_cnt    = sub_cnt_q;

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboard bench for guess_entry: stimulus queues expected submissions and
// rejects, a negedge monitor pops and compares them and times busy.
module tb_guess_entry;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] num1, num2, num3;
    logic       num_rdy, busy, key_reject;
    logic [1:0] ent_cnt;
    logic [7:0] sub_cnt;

    guess_entry #(.HOLD_CYCLES(HOLD), .GCNT_W(8)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .num1(num1), .num2(num2), .num3(num3), .num_rdy(num_rdy),
        .ent_cnt(ent_cnt), .busy(busy), .key_reject(key_reject), .sub_cnt(sub_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b, c;
        logic [7:0] s;
    } sub_t;

    sub_t sub_q[$];
    int   rej_pend = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   run      = 0;
    logic prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT pulses an output.
    always @(negedge clk) begin
        if (!reset) begin
            run      = 0;
            prev_rdy = 1'b0;
        end else begin
            if (num_rdy) begin
                chk("rdy_consecutive", 32'(prev_rdy), 0);
                if (sub_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_num_rdy: got 1 expected 0 at %0t", $time);
                end else begin
                    sub_t e;
                    e = sub_q.pop_front();
                    chk("num1", 32'(num1), 32'(e.a));
                    chk("num2", 32'(num2), 32'(e.b));
                    chk("num3", 32'(num3), 32'(e.c));
                    chk("sub_cnt", 32'(sub_cnt), 32'(e.s));
                    chk("busy_with_rdy", 32'(busy), 1);
                    chk("ent_after_sub", 32'(ent_cnt), 0);
                end
            end
            if (key_reject) begin
                if (rej_pend == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_key_reject: got 1 expected 0 at %0t", $time);
                end else begin
                    rej_pend--;
                    chk("key_reject", 32'(key_reject), 1);
                end
            end
            if (busy) run++;
            else if (run != 0) begin
                chk("busy_length", 32'(run), HOLD);
                run = 0;
            end
            prev_rdy = num_rdy;
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic key_rej(input logic [3:0] c);
        rej_pend++;
        key(c);
    endtask

    task automatic submit(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [7:0] s);
        sub_t e;
        e.a = a; e.b = b; e.c = c; e.s = s;
        sub_q.push_back(e);
        key(4'hF);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_num1"}, 32'(num1), 0);
        chk({tag, "_num2"}, 32'(num2), 0);
        chk({tag, "_num3"}, 32'(num3), 0);
        chk({tag, "_rdy"}, 32'(num_rdy), 0);
        chk({tag, "_ent"}, 32'(ent_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rej"}, 32'(key_reject), 0);
        chk({tag, "_sub"}, 32'(sub_cnt), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        #2 reset = 1'b1;
        @(negedge clk);

        // Basic submission 1,2,3
        key(4'd1); chk("ent_1", 32'(ent_cnt), 1);
        key(4'd2);
        key(4'd3); chk("ent_3", 32'(ent_cnt), 3);
        submit(4'd1, 4'd2, 4'd3, 8'd1);
        chk("busy_start", 32'(busy), 1);
        wait_idle();

        // Backspace, early enter, then completion
        key(4'd4); chk("t2_ent_a", 32'(ent_cnt), 1);
        key(4'd5); chk("t2_ent_b", 32'(ent_cnt), 2);
        key(4'hB); chk("t2_bksp", 32'(ent_cnt), 1);
        key(4'd6); chk("t2_ent_c", 32'(ent_cnt), 2);
        key_rej(4'hF); chk("t2_early_enter", 32'(ent_cnt), 2);
        key(4'd7); chk("t2_ent_d", 32'(ent_cnt), 3);
        submit(4'd4, 4'd6, 4'd7, 8'd2);

        // Keys during lockout are dropped silently
        key(4'd8); chk("hold_8", 32'(ent_cnt), 0);
        key(4'd9); chk("hold_9", 32'(ent_cnt), 0);
        key(4'hF); chk("hold_F", 32'(ent_cnt), 0);
        wait_idle();
        chk("post_hold_ent", 32'(ent_cnt), 0);
        chk("hold_num1", 32'(num1), 4);
        chk("hold_num2", 32'(num2), 6);
        chk("hold_num3", 32'(num3), 7);

        // Overflow digit, clear, enter on empty buffer
        key(4'd1); key(4'd2); key(4'd3);
        key_rej(4'd4); chk("t4_full", 32'(ent_cnt), 3);
        key(4'hE); chk("t4_clear", 32'(ent_cnt), 0);
        key_rej(4'hF); chk("t4_enter_empty", 32'(ent_cnt), 0);
        key(4'hB); chk("bksp_empty", 32'(ent_cnt), 0);
        key(4'hA); key(4'hC); key(4'hD);
        chk("ignored_codes", 32'(ent_cnt), 0);

        // Duplicate digits
        key(4'd5);
`ifdef GUESS_DISTINCT_EN
        key_rej(4'd5); chk("dup_5", 32'(ent_cnt), 1);
`else
        key(4'd5); chk("dup_5", 32'(ent_cnt), 2);
`endif
        key(4'hE);
        chk("num_stable", 32'(num3), 7);

        // Counter saturation, then asynchronous reset mid-lockout
        reset = 1'b0;
        @(negedge clk);
        chk("reset2_sub", 32'(sub_cnt), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int s = 1; s <= 256; s++) begin
            key(4'd1); key(4'd2); key(4'd3);
            submit(4'd1, 4'd2, 4'd3, (s > 255) ? 8'd255 : 8'(s));
            if (s != 256) wait_idle();
        end
        chk("sat_sub", 32'(sub_cnt), 255);
        chk("sat_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("async");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        chk("sub_q_drained", 32'(sub_q.size()), 0);
        chk("rej_drained", 32'(rej_pend), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
